// File: rtl/vend_ctrl.sv
// vend_ctrl: vending transaction controller (credit, vend, refund); define VEND_TIMEOUT_EN for idle auto-refund
module vend_ctrl #(
  parameter logic [5:0]  PRICE_A     = 6'd5,
  parameter logic [5:0]  PRICE_B     = 6'd10,
  parameter logic [28:0] TIMEOUT_CYC = 29'd500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_half,
  input  logic       coin_one,
  input  logic       coin_five,
  input  logic       sel_a,
  input  logic       sel_b,
  input  logic       cancel,
  output logic       hold,
  output logic [5:0] coin_sum,
  output logic       dispense_a,
  output logic       dispense_b,
  output logic [5:0] change,
  output logic       change_valid,
  output logic       coin_reject,
  output logic       short
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, REFUND} state_t;
  state_t state, state_n;
  logic [5:0] coin_val, sum_n, change_n;
  logic [6:0] sum_add;
  logic coin_any, coin_multi, hold_n, da_n, db_n, cv_n, rej_n, short_n, refund, timeout;
  assign coin_val   = coin_five ? 6'd10 : coin_one ? 6'd2 : coin_half ? 6'd1 : 6'd0;
  assign coin_any   = coin_half | coin_one | coin_five;
  assign coin_multi = (coin_half & coin_one) | (coin_half & coin_five) | (coin_one & coin_five);
  assign sum_add    = {1'b0, coin_sum} + {1'b0, coin_val};
  always_comb begin
    state_n  = state;
    sum_n    = coin_sum;
    hold_n   = hold;
    change_n = change;
    da_n     = 1'b0;
    db_n     = 1'b0;
    cv_n     = 1'b0;
    rej_n    = 1'b0;
    short_n  = 1'b0;
    refund   = 1'b0;
    case (state)
      IDLE: begin
        hold_n = 1'b0;
        sum_n  = 6'd0;
        if (coin_any) begin
          state_n = COLLECT;
          sum_n   = coin_val;
          hold_n  = 1'b1;
          rej_n   = coin_multi;
        end
      end
      COLLECT: begin
        hold_n = 1'b1;
        if (cancel) begin
          refund = 1'b1;
          rej_n  = coin_any;
        end else if (sel_a) begin
          rej_n = coin_any;
          if (coin_sum >= PRICE_A) begin
            state_n = VEND;
            sum_n   = coin_sum - PRICE_A;
            da_n    = 1'b1;
          end else short_n = 1'b1;
        end else if (sel_b) begin
          rej_n = coin_any;
          if (coin_sum >= PRICE_B) begin
            state_n = VEND;
            sum_n   = coin_sum - PRICE_B;
            db_n    = 1'b1;
          end else short_n = 1'b1;
        end else if (coin_any) begin
          sum_n = sum_add[6] ? coin_sum : sum_add[5:0];
          rej_n = sum_add[6] | coin_multi;
        end else if (timeout) refund = 1'b1;
      end
      VEND: begin
        rej_n  = coin_any;
        refund = 1'b1;
      end
      default: begin
        rej_n   = coin_any;
        state_n = IDLE;
        hold_n  = 1'b0;
        sum_n   = 6'd0;
      end
    endcase
    // refund outputs appear on entry, so REFUND itself only returns to IDLE
    if (refund) begin
      state_n  = REFUND;
      change_n = coin_sum;
      cv_n     = 1'b1;
      sum_n    = 6'd0;
      hold_n   = 1'b0;
    end
  end
`ifdef VEND_TIMEOUT_EN
  logic [28:0] idle_cnt;
  always_ff @(posedge clk)
    idle_cnt <= (rst || state != COLLECT || short_n || sum_n != coin_sum) ? 29'd0 : idle_cnt + 29'd1;
  assign timeout = idle_cnt == TIMEOUT_CYC - 29'd1;
`else
  assign timeout = 1'b0 & (TIMEOUT_CYC == 29'd0);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold         <= 1'b0;
      coin_sum     <= 6'd0;
      change       <= 6'd0;
      dispense_a   <= 1'b0;
      dispense_b   <= 1'b0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      short        <= 1'b0;
    end else begin
      state        <= state_n;
      hold         <= hold_n;
      coin_sum     <= sum_n;
      change       <= change_n;
      dispense_a   <= da_n;
      dispense_b   <= db_n;
      change_valid <= cv_n;
      coin_reject  <= rej_n;
      short        <= short_n;
    end
  end
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: directed scoreboard bench for vend_ctrl
module tb_vend_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic coin_half = 1'b0, coin_one = 1'b0, coin_five = 1'b0, sel_a = 1'b0, sel_b = 1'b0, cancel = 1'b0;
  logic hold, dispense_a, dispense_b, change_valid, coin_reject, short;
  logic [5:0] coin_sum, change;
  always #5 clk = ~clk;
  vend_ctrl #(.TIMEOUT_CYC(29'd20)) dut (
    .clk(clk), .rst(rst), .coin_half(coin_half), .coin_one(coin_one), .coin_five(coin_five),
    .sel_a(sel_a), .sel_b(sel_b), .cancel(cancel), .hold(hold), .coin_sum(coin_sum),
    .dispense_a(dispense_a), .dispense_b(dispense_b), .change(change),
    .change_valid(change_valid), .coin_reject(coin_reject), .short(short)
  );
  typedef struct {string tag; logic [17:0] v;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  localparam logic [5:0] N = 6'd0, H = 6'd32, O = 6'd16, F = 6'd8, A = 6'd4, B = 6'd2, C = 6'd1;
  function automatic logic [17:0] e(input int h, s, da, db, ch, cv, rj, sh);
    return {h[0], s[5:0], da[0], db[0], ch[5:0], cv[0], rj[0], sh[0]};
  endfunction
  task automatic step(input string tag, input logic [5:0] in, input logic [17:0] ex);
    exp_t x;
    logic [17:0] got;
    @(negedge clk);
    {coin_half, coin_one, coin_five, sel_a, sel_b, cancel} = in;
    sb.push_back('{tag, ex});
    @(posedge clk);
    #1;
    {coin_half, coin_one, coin_five, sel_a, sel_b, cancel} = 6'd0;
    x = sb.pop_front();
    got = {hold, coin_sum, dispense_a, dispense_b, change, change_valid, coin_reject, short};
    checks++;
    assert (got === x.v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", x.tag, got, x.v);
    end
  endtask
  initial begin
    step("reset", N, e(0,0,0,0,0,0,0,0));
    rst = 1'b0;
    step("one_2", O, e(1,2,0,0,0,0,0,0));
    step("one_4", O, e(1,4,0,0,0,0,0,0));
    step("half_5", H, e(1,5,0,0,0,0,0,0));
    step("sel_a_disp", A, e(1,0,1,0,0,0,0,0));
    step("refund_0", N, e(0,0,0,0,0,1,0,0));
    step("idle_0", N, e(0,0,0,0,0,0,0,0));
    step("sel_a_idle", A, e(0,0,0,0,0,0,0,0));
    step("one_2b", O, e(1,2,0,0,0,0,0,0));
    step("half_3", H, e(1,3,0,0,0,0,0,0));
    step("sel_b_short", B, e(1,3,0,0,0,0,0,1));
    step("five_13", F, e(1,13,0,0,0,0,0,0));
    step("sel_b_disp", B, e(1,3,0,1,0,0,0,0));
    step("refund_3", N, e(0,0,0,0,3,1,0,0));
    step("idle_chg3", N, e(0,0,0,0,3,0,0,0));
    for (int i = 1; i <= 5; i++) step("five_acc", F, e(1,10*i,0,0,3,0,0,0));
    for (int i = 1; i <= 4; i++) step("one_acc", O, e(1,50+2*i,0,0,3,0,0,0));
    step("sat_reject", F, e(1,58,0,0,3,0,1,0));
    step("half_59", H, e(1,59,0,0,3,0,0,0));
    step("multi_sat", O|F, e(1,59,0,0,3,0,1,0));
    step("cancel_59", C, e(0,0,0,0,59,1,0,0));
    step("idle_chg59", N, e(0,0,0,0,59,0,0,0));
    step("multi_idle", H|O, e(1,2,0,0,59,0,1,0));
    step("one_4c", O, e(1,4,0,0,59,0,0,0));
    step("one_6", O, e(1,6,0,0,59,0,0,0));
    step("cancel_prio", C|A|O, e(0,0,0,0,6,1,1,0));
    step("idle_chg6", N, e(0,0,0,0,6,0,0,0));
    step("half_1", H, e(1,1,0,0,6,0,0,0));
    step("short_drop", A|O, e(1,1,0,0,6,0,1,1));
    step("five_11", F, e(1,11,0,0,6,0,0,0));
    step("sel_ab", A|B, e(1,6,1,0,6,0,0,0));
    step("vend_coin", H, e(0,0,0,0,6,1,1,0));
    step("refund_coin", H, e(0,0,0,0,6,0,1,0));
    step("five_10", F, e(1,10,0,0,6,0,0,0));
    step("sel_a_rst", A, e(1,5,1,0,6,0,0,0));
    rst = 1'b1;
    step("rst_vend", N, e(0,0,0,0,0,0,0,0));
    rst = 1'b0;
    step("after_rst", N, e(0,0,0,0,0,0,0,0));
`ifdef VEND_TIMEOUT_EN
    step("to_one", O, e(1,2,0,0,0,0,0,0));
    for (int i = 0; i < 14; i++) step("to_wait1", N, e(1,2,0,0,0,0,0,0));
    step("to_half", H, e(1,3,0,0,0,0,0,0));
    for (int i = 0; i < 19; i++) step("to_wait2", N, e(1,3,0,0,0,0,0,0));
    step("to_refund", N, e(0,0,0,0,3,1,0,0));
    step("to_idle", N, e(0,0,0,0,3,0,0,0));
`else
    for (int i = 0; i < 30; i++) step("no_timeout", N, e(0,0,0,0,0,0,0,0));
    step("hold_one", O, e(1,2,0,0,0,0,0,0));
    for (int i = 0; i < 30; i++) step("collect_stays", N, e(1,2,0,0,0,0,0,0));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
